// File: rtl/top_system_pkg.sv
// rtl/top_system_pkg.sv - shared types and constants for the UART echo-adder
package top_system_pkg;

    typedef enum logic [1:0] {READ, ECHO, EMIT, HALT} ctrl_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 64;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Non-digit characters contribute nothing to the sum.
    function automatic logic [3:0] digit_value(input logic [7:0] b);
        return (b >= ASCII_0 && b <= ASCII_9) ? b[3:0] : 4'd0;
    endfunction

endpackage

// File: rtl/top_system_ctrl.sv
// rtl/top_system_ctrl.sv - reads two operands, echoes them, emits "=<sum>\r\n" and halts
module top_system_ctrl import top_system_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_empty,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_pop,
    input  logic       i_tx_full,
    output logic       o_tx_push,
    output logic [7:0] o_tx_data
);
    ctrl_state_t r_state, w_next;
    logic [7:0]  r_byte;
    logic        r_op_cnt;
    logic [3:0]  r_op_a, r_op_b;
    logic [2:0]  r_idx;
    logic        halt;
    logic [4:0]  w_sum;
    logic        w_two_digit;
    logic [2:0]  w_last_idx;
    logic [7:0]  w_emit_byte;

    assign w_sum       = {1'b0, r_op_a} + {1'b0, r_op_b};
    assign w_two_digit = (w_sum >= 5'd10);
    assign w_last_idx  = w_two_digit ? 3'd4 : 3'd3;

    always_comb begin
        w_emit_byte = ASCII_LF;
        case (r_idx)
            3'd0:    w_emit_byte = ASCII_EQ;
            3'd1:    w_emit_byte = w_two_digit ? ASCII_0 + 8'd1 : ASCII_0 + {3'b0, w_sum};
            3'd2:    w_emit_byte = w_two_digit ? ASCII_0 + {3'b0, w_sum - 5'd10} : ASCII_CR;
            3'd3:    w_emit_byte = w_two_digit ? ASCII_CR : ASCII_LF;
            default: w_emit_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= READ;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            READ:    if (!i_rx_empty) w_next = ECHO;
            ECHO:    if (!i_tx_full) w_next = r_op_cnt ? EMIT : READ;
            EMIT:    if (!i_tx_full && r_idx == w_last_idx) w_next = HALT;
            HALT:    w_next = HALT;
            default: w_next = READ;
        endcase
    end

    always_comb begin
        halt      = (r_state == HALT);
        o_rx_pop  = (r_state == READ) && !i_rx_empty && !halt;
        o_tx_push = ((r_state == ECHO) || (r_state == EMIT)) && !i_tx_full;
        o_tx_data = (r_state == ECHO) ? r_byte : w_emit_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte   <= '0;
            r_op_cnt <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_idx    <= '0;
        end else begin
            if (o_rx_pop) r_byte <= i_rx_data;
            if (r_state == ECHO && o_tx_push) begin
                r_op_cnt <= 1'b1;
                if (!r_op_cnt) r_op_a <= digit_value(r_byte);
                else           r_op_b <= digit_value(r_byte);
            end
            if (r_state == EMIT && o_tx_push) r_idx <= r_idx + 3'd1;
        end
    end

endmodule

// File: rtl/top_system_fifo.sv
// rtl/top_system_fifo.sv - show-ahead byte FIFO, full pushes and empty pops ignored
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/top_system_uart_core.sv
// rtl/top_system_uart_core.sv - 8N1 UART receiver and transmitter with RX/TX byte FIFOs
module uart_core import top_system_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       i_rx_pop,
    output logic [7:0] o_rx_data,
    output logic       o_rx_empty,
    input  logic       i_tx_push,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_full
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_rx_meta, r_rx_sync, r_rx_prev, r_rx_busy, r_rx_valid;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          w_rx_full;

    logic          r_tx, r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [7:0]    r_tx_data;
    logic          w_tx_fifo_empty, w_tx_start;
    logic [7:0]    w_tx_fifo_data;

    logic          tx_empty;
    logic          tx_done_tick;
    logic [7:0]    tx_fifo_out;

    // r_rx_bit: 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= HALF_LAST;
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - CW'(1);
            end else begin
                r_rx_cnt <= BIT_LAST;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_sync) r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= r_rx_sync;
                end else begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                end
            end
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n),
        .i_push(r_rx_valid && !w_rx_full), .i_data(r_rx_shift),
        .i_pop(i_rx_pop), .o_data(o_rx_data),
        .o_empty(o_rx_empty), .o_full(w_rx_full)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n),
        .i_push(i_tx_push), .i_data(i_tx_data),
        .i_pop(w_tx_start), .o_data(w_tx_fifo_data),
        .o_empty(w_tx_fifo_empty), .o_full(o_tx_full)
    );

    assign tx_empty     = w_tx_fifo_empty && !r_tx_busy;
    assign w_tx_start   = !tx_empty && !r_tx_busy;
    assign tx_done_tick = r_tx_busy && (r_tx_cnt == '0) && (r_tx_bit == 4'd9);
    assign tx_fifo_out  = r_tx_data;
    assign o_tx         = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_data <= '0;
        end else if (w_tx_start) begin
            r_tx_busy <= 1'b1;
            r_tx_data <= w_tx_fifo_data;
            r_tx_cnt  <= BIT_LAST;
            r_tx_bit  <= '0;
            r_tx      <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - CW'(1);
            end else if (tx_done_tick) begin
                r_tx_busy <= 1'b0;
            end else begin
                r_tx_cnt <= BIT_LAST;
                r_tx_bit <= r_tx_bit + 4'd1;
                r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : tx_fifo_out[r_tx_bit[2:0]];
            end
        end
    end

endmodule

// File: rtl/top_system.sv
// rtl/top_system.sv - UART two-digit adder: uart_core plus controller
module top_system import top_system_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx
);
    logic       w_rx_pop, w_rx_empty, w_tx_push, w_tx_full;
    logic [7:0] w_rx_data, w_tx_data;

    uart_core #(.CLKS_PER_BIT(CLKS_PER_BIT), .FIFO_DEPTH(FIFO_DEPTH)) uart (
        .clk(clk), .rst_n(reset), .i_rx(rx), .o_tx(tx),
        .i_rx_pop(w_rx_pop), .o_rx_data(w_rx_data), .o_rx_empty(w_rx_empty),
        .i_tx_push(w_tx_push), .i_tx_data(w_tx_data), .o_tx_full(w_tx_full)
    );

    top_system_ctrl cpu (
        .clk(clk), .rst_n(reset),
        .i_rx_empty(w_rx_empty), .i_rx_data(w_rx_data), .o_rx_pop(w_rx_pop),
        .i_tx_full(w_tx_full), .o_tx_push(w_tx_push), .o_tx_data(w_tx_data)
    );

endmodule

// File: tb/tb_top_system.sv
// tb/tb_top_system.sv - self-checking bench for top_system
`timescale 1ns/1ps
module tb_top_system;
    import top_system_pkg::*;

    localparam int  CPB      = 64;
    localparam real CLK_HALF = 31.25;
    localparam int  BIT_NS   = 4000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic tx;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic r_prev_tick = 1'b0;
    logic [7:0] q_tx[$];
    logic [7:0] q_exp[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          glitch;
        logic [55:0] exp;
        int          len;
    } vec_t;
    vec_t vecs[4];

    top_system #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx)
    );

    always #(CLK_HALF) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line-level decoder of the serial output.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge tx);
            #(BIT_NS / 2);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    #(BIT_NS);
                    b[i] = tx;
                end
                #(BIT_NS);
                q_tx.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (dut.uart.tx_done_tick) begin
            logic [7:0] last;
            n_done++;
            last = (q_tx.size() > 0) ? q_tx[q_tx.size()-1] : 8'hxx;
            check("done_tick_byte", dut.uart.tx_fifo_out, last);
            check("done_tick_single", r_prev_tick, 1'b0);
        end
        r_prev_tick <= dut.uart.tx_done_tick;
    end

    initial begin : watchdog
        #5_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int digit_of(input logic [7:0] c);
        return (c >= "0" && c <= "9") ? int'(c) - 48 : 0;
    endfunction

    task automatic model_pair(input logic [7:0] a, input logic [7:0] b);
        string s;
        q_exp.delete();
        q_exp.push_back(a);
        q_exp.push_back(b);
        s = $sformatf("=%0d\r\n", digit_of(a) + digit_of(b));
        for (int i = 0; i < s.len(); i++) q_exp.push_back(s[i]);
    endtask

    task automatic do_reset();
        rx = 1'b1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        q_tx.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!(dut.cpu.halt && dut.uart.tx_empty) && k < 12000) begin
            @(posedge clk);
            k++;
        end
        check({name, "_timeout"}, (k < 12000) ? 1 : 0, 1);
        #(2 * BIT_NS);
    endtask

    task automatic check_seq(input string name);
        logic [7:0] got;
        check({name, "_len"}, q_tx.size(), q_exp.size());
        for (int i = 0; i < q_exp.size(); i++) begin
            got = (i < q_tx.size()) ? q_tx[i] : 8'hxx;
            check($sformatf("%s_byte%0d", name, i), got, q_exp[i]);
        end
    endtask

    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input bit glitch, input string name);
        do_reset();
        if (glitch) begin
            @(posedge clk); #1;
            rx = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (200) @(posedge clk);
        end
        send_byte(a);
        send_byte(b);
        wait_done(name);
        check_seq(name);
        check({name, "_halt"}, dut.cpu.halt, 1'b1);
        check({name, "_tx_empty"}, dut.uart.tx_empty, 1'b1);
    endtask

    initial begin : main
        logic [7:0] ra, rb;
        logic [1:0] idx;
        int base, k;

        vecs[0] = '{8'h31, 8'h32, 1'b0, "12=3\r\n",  6};
        vecs[1] = '{8'h39, 8'h38, 1'b0, "98=17\r\n", 7};
        vecs[2] = '{8'h41, 8'h35, 1'b0, "A5=5\r\n",  6};
        vecs[3] = '{8'h33, 8'h34, 1'b1, "34=7\r\n",  6};

        #100;
        check("rst_tx", tx, 1'b1);
        check("rst_halt", dut.cpu.halt, 1'b0);
        check("rst_tx_empty", dut.uart.tx_empty, 1'b1);
        check("rst_done_tick", dut.uart.tx_done_tick, 1'b0);
        check("rst_tx_fifo_out", dut.uart.tx_fifo_out, 8'h00);
        check("rst_rx_count", dut.uart.u_rx_fifo.r_count, 0);
        check("rst_state", dut.cpu.r_state, READ);

        for (int v = 0; v < 4; v++) begin
            q_exp.delete();
            for (int i = 0; i < vecs[v].len; i++)
                q_exp.push_back(vecs[v].exp[8*(vecs[v].len-1-i) +: 8]);
            run_pair(vecs[v].a, vecs[v].b, vecs[v].glitch, $sformatf("vec%0d", v));
        end

        // Bytes arriving after halt are buffered up to FIFO depth, never echoed.
        base = q_tx.size();
        for (int i = 0; i < 6; i++) send_byte(8'h61 + 8'(i));
        #(2 * BIT_NS);
        check("post_halt_no_tx", q_tx.size(), base);
        check("post_halt_halt", dut.cpu.halt, 1'b1);
        check("post_halt_rx_count", dut.uart.u_rx_fifo.r_count, 4);
        for (int i = 0; i < 4; i++) begin
            idx = dut.uart.u_rx_fifo.r_rd_ptr + 2'(i);
            check($sformatf("post_halt_rx_byte%0d", i), dut.uart.u_rx_fifo.r_mem[idx], 8'h61 + 8'(i));
        end

        for (int r = 0; r < 3; r++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h30 + 8'($urandom_range(0, 9));
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h30 + 8'($urandom_range(0, 9));
            model_pair(ra, rb);
            run_pair(ra, rb, 1'b0, $sformatf("rand%0d", r));
        end

        // Reset in the middle of the '=' frame.
        do_reset();
        base = n_done;
        send_byte("1");
        send_byte("2");
        k = 0;
        while (n_done < base + 2 && k < 8000) begin
            @(posedge clk);
            k++;
        end
        check("midrst_wait_timeout", (k < 8000) ? 1 : 0, 1);
        #(BIT_NS * 5 / 2);
        #5;
        check("midrst_tx_low_before", tx, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_tx_high", tx, 1'b1);
        check("midrst_halt", dut.cpu.halt, 1'b0);
        check("midrst_rx_count", dut.uart.u_rx_fifo.r_count, 0);
        check("midrst_tx_count", dut.uart.u_tx_fifo.r_count, 0);
        check("midrst_tx_empty", dut.uart.tx_empty, 1'b1);
        check("midrst_tx_fifo_out", dut.uart.tx_fifo_out, 8'h00);
        #(BIT_NS / 2);
        reset = 1'b1;
        #(12 * BIT_NS);
        q_tx.delete();
        model_pair("1", "1");
        send_byte("1");
        send_byte("1");
        wait_done("midrst_resend");
        check_seq("midrst_resend");
        check("midrst_resend_halt", dut.cpu.halt, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_system.md
TOP_SYSTEM -- requirements
Module: top_system

Interface
REQ-001 Parameter CLKS_PER_BIT, default 64, meaning clk cycles per UART bit (250000 baud at 16 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning entries in each of the RX and TX byte FIFOs (power of two).
REQ-003 Port clk  input  1  system clock, 16 MHz nominal, all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (reset=0 resets; reset=1 runs).
REQ-005 Port rx  input  1  UART serial in, 8N1, LSB first, idle high.
REQ-006 Port tx  output  1  UART serial out, 8N1, LSB first, idle high.

Function
REQ-007 rx SHALL be double-flop synchronised before use.
REQ-008 The receiver SHALL detect a falling edge when idle, sample at mid-bit (CLKS_PER_BIT/2 after the edge), then every CLKS_PER_BIT cycles for 8 data bits and the stop bit.
REQ-009 A start bit that reads high at mid-bit SHALL be discarded as a glitch; a stop bit that reads low SHALL drop the byte.
REQ-010 A valid byte SHALL be pushed into the RX FIFO; when the RX FIFO is full, the new byte SHALL be dropped and stored bytes SHALL be kept.
REQ-011 The transmitter SHALL pop the TX FIFO when idle and not empty, send start, 8 data bits, stop, each CLKS_PER_BIT cycles.
REQ-012 tx_done_tick SHALL pulse for exactly one cycle at the end of each stop bit; tx_fifo_out SHALL hold the byte just sent during that cycle.
REQ-013 tx_empty SHALL be 1 only when the TX FIFO is empty and the transmitter is idle.
REQ-014 FIFOs SHALL support push and pop in the same cycle; push to full SHALL be ignored; pop from empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 The controller FSM SHALL use states READ, ECHO, EMIT, HALT.
REQ-016 In READ, the controller SHALL pop one RX byte when the RX FIFO is non-empty, then go to ECHO.
REQ-017 In ECHO, the controller SHALL push the byte to the TX FIFO when not full, stalling while full.
REQ-018 After ECHO of operand 1, the controller SHALL return to READ; after ECHO of operand 2, it SHALL go to EMIT.
REQ-019 Operand value SHALL be byte-0x30 for ASCII '0'..'9'; any other byte SHALL count as 0 but SHALL still be echoed.
REQ-020 In EMIT, the controller SHALL push in order: '=', the decimal sum of both operand values (one digit if <10, else '1' then the units digit), 0x0D, 0x0A, stalling on TX full, then go to HALT.
REQ-021 In HALT, halt SHALL be 1 and remain so until reset; further RX bytes SHALL be buffered but not processed.
REQ-022 Internal status signals halt, tx_empty, tx_done_tick and tx_fifo_out SHALL be reachable by hierarchical reference (cpu.halt, uart.tx_empty, uart.tx_done_tick, uart.tx_fifo_out).

Reset
REQ-023 While reset=0: tx=1, both FIFOs empty, receiver/transmitter idle, tx_done_tick=0, tx_fifo_out=0, halt=0, controller in READ with operand count 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, driving tx high; after release, the receiver SHALL wait for a new falling edge.

Structure
REQ-025 A shared package SHALL hold the controller state enum, ASCII constants ('0', '=', CR, LF) and the default CLKS_PER_BIT.
REQ-026 The top level SHALL instantiate one sub-module uart_core (instance name uart), containing RX, TX and both FIFOs, plus the controller FSM (instance name cpu).

Verification
REQ-027 Send '1' then '2' at 4000 ns/bit -> TX bytes "12=3\r\n", then halt=1 and tx_empty=1.
REQ-028 Send '9' then '8' -> TX "98=17\r\n", then halt.
REQ-029 Send 'A' then '5' -> TX "A5=5\r\n" (non-digit counts as 0).
REQ-030 Send a start-bit glitch of 10 clk low, then '3','4' -> glitch ignored; TX "34=7\r\n".
REQ-031 Assert reset mid-transmission of '=' -> tx high within 1 cycle, halt=0, FIFOs empty; resending '1','1' -> TX "11=2\r\n".
REQ-032 After halt, send 6 more bytes -> no TX activity; RX FIFO holds the first 4 bytes, halt stays 1.
